// File: rtl/mmcm_ps_sequencer_if.sv
// rtl/mmcm_ps_sequencer_if.sv - command channel bundle for the MMCM phase-shift sequencer
//
// Signals:
//   req_valid  command valid (master -> slave)
//   req_ready  command accepted when valid & ready (slave -> master)
//   req_dir    1 = increment phase, 0 = decrement (master -> slave)
//   req_steps  number of phase steps, 0 legal (master -> slave)
interface mmcm_ps_sequencer_if #(
    parameter int STEPS_W = 12
) ();
    logic               req_valid;
    logic               req_ready;
    logic               req_dir;
    logic [STEPS_W-1:0] req_steps;

    modport master (
        output req_valid,
        output req_dir,
        output req_steps,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dir,
        input  req_steps,
        output req_ready
    );
endinterface

// File: rtl/mmcm_ps_sequencer.sv
// rtl/mmcm_ps_sequencer.sv - multi-step MMCM dynamic phase-shift sequencer
//
// Ports:
//   clk          clock (same clock as the MMCM psclk)
//   aresetn      asynchronous active-low reset, released synchronously upstream
//   req          command channel (slave side): req_valid/req_ready/req_dir/req_steps
//   abort        level; ends the current command at the next safe point
//   psen         one-cycle strobe to MMCM PSEN
//   psincdec     direction to MMCM PSINCDEC, held at the latched command direction
//   psdone       from MMCM PSDONE
//   busy         command in progress
//   done         one-cycle pulse when a command terminates
//   steps_done   steps completed in the current/last command
//   position     signed accumulated phase position in steps
//   err_limit    sticky: command stopped at +/-POS_LIMIT
//   err_timeout  sticky: PSDONE not seen within TIMEOUT_CYC cycles
//   aborted      sticky: last command ended by abort
module mmcm_ps_sequencer #(
    parameter int PERIOD_NS   = 10,
    parameter int INTERVAL_NS = 1000,
    parameter int STEPS_W     = 12,
    parameter int POS_W       = 16,
    parameter int POS_LIMIT   = 1120,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    aresetn,
    mmcm_ps_sequencer_if.slave      req,
    input  logic                    abort,
    output logic                    psen,
    output logic                    psincdec,
    input  logic                    psdone,
    output logic                    busy,
    output logic                    done,
    output logic [STEPS_W-1:0]      steps_done,
    output logic signed [POS_W-1:0] position,
    output logic                    err_limit,
    output logic                    err_timeout,
    output logic                    aborted
);

    localparam int GAP_RAW = INTERVAL_NS / PERIOD_NS;
    localparam int GAP     = (GAP_RAW < 1) ? 1 : GAP_RAW;
    localparam int GCNT_W  = $clog2(GAP + 1);
    localparam int TCNT_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic signed [POS_W-1:0] POS_MAX = POS_W'(POS_LIMIT);
    localparam logic signed [POS_W-1:0] POS_MIN = -POS_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_STROBE,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state, state_d;
    logic [STEPS_W-1:0] remaining;
    logic [GCNT_W-1:0]  gcnt;
    logic [TCNT_W-1:0]  tcnt;
    logic               rdy_q;

    logic accept, step_ok, end_cmd, set_abort, set_limit, set_timeout;
    logic at_limit;

    // Limit stops only a step that would move further toward the limit.
    assign at_limit = psincdec ? (position == POS_MAX) : (position == POS_MIN);

    assign psen          = (state == S_STROBE);
    assign busy          = (state != S_IDLE);
    // rdy_q keeps req_ready low while reset is asserted.
    assign req.req_ready = (state == S_IDLE) && rdy_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        step_ok     = 1'b0;
        end_cmd     = 1'b0;
        set_abort   = 1'b0;
        set_limit   = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (req.req_valid && req.req_ready) begin
                    accept = 1'b1;
                    if (req.req_steps == '0) begin
                        end_cmd = 1'b1;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    end_cmd   = 1'b1;
                    set_abort = 1'b1;
                end else if (at_limit) begin
                    state_d   = S_IDLE;
                    end_cmd   = 1'b1;
                    set_limit = 1'b1;
                end else begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // Abort is only honoured once the MMCM has acknowledged the step.
                if (psdone) begin
                    step_ok = 1'b1;
                    if (remaining == STEPS_W'(1)) begin
                        state_d = S_IDLE;
                        end_cmd = 1'b1;
                    end else if (abort) begin
                        state_d   = S_IDLE;
                        end_cmd   = 1'b1;
                        set_abort = 1'b1;
                    end else if (GAP > 1) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_CHECK;
                    end
                end else if (tcnt >= TCNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d     = S_IDLE;
                    end_cmd     = 1'b1;
                    set_timeout = 1'b1;
                end
            end
            S_GAP: begin
                // The psdone cycle counts toward the pitch, so GAP occupies
                // GAP-1 cycles and CHECK one more: psdone-to-psen = GAP+1.
                if (abort) begin
                    state_d   = S_IDLE;
                    end_cmd   = 1'b1;
                    set_abort = 1'b1;
                end else if (gcnt == GCNT_W'(1)) begin
                    state_d = S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_q       <= 1'b0;
            psincdec    <= 1'b0;
            remaining   <= '0;
            steps_done  <= '0;
            position    <= '0;
            gcnt        <= '0;
            tcnt        <= '0;
            done        <= 1'b0;
            err_limit   <= 1'b0;
            err_timeout <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            done  <= end_cmd;

            if (accept) begin
                psincdec    <= req.req_dir;
                remaining   <= req.req_steps;
                steps_done  <= '0;
                err_limit   <= 1'b0;
                err_timeout <= 1'b0;
                aborted     <= 1'b0;
            end

            if (set_abort)   aborted     <= 1'b1;
            if (set_limit)   err_limit   <= 1'b1;
            if (set_timeout) err_timeout <= 1'b1;

            if (step_ok) begin
                position   <= psincdec ? (position + POS_W'(1)) : (position - POS_W'(1));
                steps_done <= steps_done + STEPS_W'(1);
                remaining  <= remaining - STEPS_W'(1);
            end

            if (state_d == S_GAP && state != S_GAP) begin
                gcnt <= GCNT_W'(GAP - 1);
            end else if (state == S_GAP) begin
                gcnt <= gcnt - GCNT_W'(1);
            end

            if (state == S_STROBE) begin
                tcnt <= TCNT_W'(1);
            end else if (state == S_WAIT_DONE) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
        end
    end

endmodule
